// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared video geometry, box sizes, colours and sequencer states
package game_pkg;

  localparam int VIDEO_WIDTH         = 640;
  localparam int VIDEO_HEIGHT        = 480;
  localparam int PLAYER_HALF_DEFAULT = 25;
  localparam int TARGET_HALF_DEFAULT = 30;

  localparam logic [11:0] PLAYER_COLOUR = 12'h0F0;
  localparam logic [11:0] TARGET_COLOUR = 12'hF00;
  localparam logic [11:0] BG_COLOUR     = 12'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    MOVE  = 2'd2,
    CHECK = 2'd3
  } motion_state_t;

  function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? -v : v;
  endfunction

endpackage

// File: rtl/player_motion_controller_if.sv
// rtl/player_motion_controller_if.sv - frame strobe, buttons, target and player/score outputs
interface player_motion_controller_if #(
  parameter int SCORE_W = 16
);
  logic               screenEnd;
  logic               BTNU;
  logic               BTND;
  logic               BTNL;
  logic               BTNR;
  logic [9:0]         target_x;
  logic [8:0]         target_y;
  logic [9:0]         player_x;
  logic [8:0]         player_y;
  logic               hit;
  logic [SCORE_W-1:0] score;
  logic               busy;

  modport master (
    output screenEnd, BTNU, BTND, BTNL, BTNR, target_x, target_y,
    input  player_x, player_y, hit, score, busy
  );

  modport slave (
    input  screenEnd, BTNU, BTND, BTNL, BTNR, target_x, target_y,
    output player_x, player_y, hit, score, busy
  );
endinterface

// File: rtl/axis_step_clamp.sv
// rtl/axis_step_clamp.sv - one axis of the per-frame move: step by speed, clamp to [lo, hi]
module axis_step_clamp #(
  parameter int W     = 10,
  parameter int SPD_W = 4
) (
  input  logic [W-1:0]     pos,
  input  logic [SPD_W-1:0] speed,
  input  logic             inc,
  input  logic             dec,
  input  logic [W-1:0]     lo,
  input  logic [W-1:0]     hi,
  output logic [W-1:0]     next_pos
);

  logic signed [10:0] pos_s;
  logic signed [10:0] spd_s;
  logic signed [10:0] lo_s;
  logic signed [10:0] hi_s;
  logic signed [10:0] stepped;

  // 11-bit signed so a step below zero clamps to lo rather than wrapping high
  always_comb begin
    pos_s   = {{(11-W){1'b0}}, pos};
    spd_s   = {{(11-SPD_W){1'b0}}, speed};
    lo_s    = {{(11-W){1'b0}}, lo};
    hi_s    = {{(11-W){1'b0}}, hi};
    stepped = pos_s;
    if (inc && !dec) begin
      stepped = pos_s + spd_s;
    end else if (dec && !inc) begin
      stepped = pos_s - spd_s;
    end
    if (stepped < lo_s) begin
      next_pos = lo;
    end else if (stepped > hi_s) begin
      next_pos = hi;
    end else begin
      next_pos = stepped[W-1:0];
    end
  end

endmodule

// File: rtl/player_motion_controller.sv
// rtl/player_motion_controller.sv - per-frame player move with speed ramp, wall clamp and target hit scoring
module player_motion_controller
  import game_pkg::*;
#(
  parameter int PLAYER_HALF     = PLAYER_HALF_DEFAULT,
  parameter int TARGET_HALF     = TARGET_HALF_DEFAULT,
  parameter int MAX_SPEED       = 8,
  parameter int ACCEL_FRAMES    = 4,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int SCORE_W         = 16
) (
  input  logic                       clk_25mHz,
  input  logic                       reset,
  player_motion_controller_if.slave  bus
);

  localparam int SPD_W    = $clog2(MAX_SPEED + 1);
  localparam int HELD_W   = $clog2(ACCEL_FRAMES + 1);
  localparam int CD_W     = $clog2(COOLDOWN_FRAMES + 1);
  localparam int HIT_DIST = PLAYER_HALF + TARGET_HALF;

  localparam logic [9:0] X_LO = 10'(PLAYER_HALF);
  localparam logic [9:0] X_HI = 10'(VIDEO_WIDTH - 1 - PLAYER_HALF);
  localparam logic [8:0] Y_LO = 9'(PLAYER_HALF);
  localparam logic [8:0] Y_HI = 9'(VIDEO_HEIGHT - 1 - PLAYER_HALF);

  motion_state_t state;
  motion_state_t state_next;

  // button vectors are ordered {U, D, L, R}
  logic [3:0]         btn_meta;
  logic [3:0]         btn_sync;
  logic [3:0]         dir_q;
  logic               x_inc;
  logic               x_dec;
  logic               y_inc;
  logic               y_dec;
  logic [9:0]         px;
  logic [8:0]         py;
  logic [9:0]         px_next;
  logic [8:0]         py_next;
  logic [SPD_W-1:0]   speed;
  logic [HELD_W-1:0]  held;
  logic [CD_W-1:0]    cooldown;
  logic [SCORE_W-1:0] score_q;
  logic               hit_q;
  logic               frame_start;
  logic               overlap;
  logic signed [10:0] dist_x;
  logic signed [10:0] dist_y;

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.screenEnd) begin
          state_next  = LATCH;
          frame_start = 1'b1;
        end
      end
      LATCH:   state_next = MOVE;
      MOVE:    state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  axis_step_clamp #(.W(10), .SPD_W(SPD_W)) u_step_x (
    .pos      (px),
    .speed    (speed),
    .inc      (x_inc),
    .dec      (x_dec),
    .lo       (X_LO),
    .hi       (X_HI),
    .next_pos (px_next)
  );

  axis_step_clamp #(.W(9), .SPD_W(SPD_W)) u_step_y (
    .pos      (py),
    .speed    (speed),
    .inc      (y_inc),
    .dec      (y_dec),
    .lo       (Y_LO),
    .hi       (Y_HI),
    .next_pos (py_next)
  );

  assign dist_x  = $signed({1'b0, px}) - $signed({1'b0, bus.target_x});
  assign dist_y  = $signed({2'b00, py}) - $signed({2'b00, bus.target_y});
  assign overlap = (abs11(dist_x) < 11'(HIT_DIST)) && (abs11(dist_y) < 11'(HIT_DIST));

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      dir_q    <= '0;
      x_inc    <= 1'b0;
      x_dec    <= 1'b0;
      y_inc    <= 1'b0;
      y_dec    <= 1'b0;
      px       <= 10'd320;
      py       <= 9'd240;
      speed    <= SPD_W'(1);
      held     <= '0;
      cooldown <= '0;
      score_q  <= '0;
      hit_q    <= 1'b0;
    end else begin
      btn_meta <= {bus.BTNU, bus.BTND, bus.BTNL, bus.BTNR};
      btn_sync <= btn_meta;
      hit_q    <= 1'b0;

      if (frame_start) begin
        dir_q <= btn_sync;
      end

      // opposing buttons cancel here, so the speed ramp sees them as released
      if (state == LATCH) begin
        x_inc <= dir_q[0] & ~dir_q[1];
        x_dec <= dir_q[1] & ~dir_q[0];
        y_inc <= dir_q[2] & ~dir_q[3];
        y_dec <= dir_q[3] & ~dir_q[2];
      end

      if (state == MOVE) begin
        px <= px_next;
        py <= py_next;
        if (x_inc | x_dec | y_inc | y_dec) begin
          if (held == HELD_W'(ACCEL_FRAMES - 1)) begin
            held <= '0;
            if (speed != SPD_W'(MAX_SPEED)) begin
              speed <= speed + 1'b1;
            end
          end else begin
            held <= held + 1'b1;
          end
        end else begin
          speed <= SPD_W'(1);
          held  <= '0;
        end
      end

      if (state == CHECK) begin
        if (overlap && (cooldown == '0)) begin
          hit_q    <= 1'b1;
          cooldown <= CD_W'(COOLDOWN_FRAMES);
          if (~&score_q) begin
            score_q <= score_q + 1'b1;
          end
        end else if (cooldown != '0) begin
          cooldown <= cooldown - 1'b1;
        end
      end
    end
  end

  assign bus.player_x = px;
  assign bus.player_y = py;
  assign bus.hit      = hit_q;
  assign bus.score    = score_q;
  assign bus.busy     = (state != IDLE);

endmodule
